// File: rtl/reg_file_sb_pkg.sv
// Shared constants and forwarding helpers for the register file with
// pending-write scoreboard.
package regfile_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  // Helpers take indices zero-extended to this width, which caps ADDR_W at 8.
  localparam int ADDR_W_MAX = 8;
  localparam int ZERO_IDX   = 0;

  // True when a read of rd_addr must take the write-port data of the same edge.
  function automatic logic bypass_sel(
    input logic [ADDR_W_MAX-1:0] rd_addr,
    input logic                  wr_en,
    input logic [ADDR_W_MAX-1:0] wr_addr
  );
    return wr_en && (wr_addr == rd_addr);
  endfunction

  // True when idx is the hardwired-zero register and that feature is enabled.
  function automatic logic zero_hit(
    input logic                  zero_reg,
    input logic [ADDR_W_MAX-1:0] idx
  );
    return zero_reg && (idx == ADDR_W_MAX'(ZERO_IDX));
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: forwards same-edge write data, qualifies the
// scoreboard busy bit, and holds its outputs while the enable is low.
module reg_file_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              busy_bit,
  output logic [DATA_W-1:0] data,
  output logic              busy
);

  logic fwd;
  logic is_zero;
  logic [DATA_W-1:0] data_next;
  logic busy_next;

  assign fwd     = bypass_sel(ADDR_W_MAX'(addr), wr_en, ADDR_W_MAX'(wr_addr));
  assign is_zero = zero_hit(ZERO_REG != 0, ADDR_W_MAX'(addr));

  // The zero register overrides forwarding; a same-edge write retires the pending mark.
  always_comb begin
    data_next = reg_data;
    busy_next = busy_bit;
    if (is_zero) begin
      data_next = '0;
      busy_next = 1'b0;
    end else if (fwd) begin
      data_next = wr_data;
      busy_next = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data <= '0;
      busy <= 1'b0;
    end else if (en) begin
      data <= data_next;
      busy <= busy_next;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with NUM_RD registered read ports, one write port with bypass,
// optional hardwired-zero register 0 and a per-register pending-write scoreboard.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     bsy_set,
  input  logic [ADDR_W-1:0]        bsy_addr,
  output logic                     any_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Interface timing: no handshake. A read issued with rd_en[p] at one edge is
  // presented on rd_data/rd_busy port p after that edge and held until the next
  // enabled read on that port; writes and busy marks complete at the edge.

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;
  logic              wr_ok;
  logic              set_ok;

  assign wr_ok  = wr_en   && !zero_hit(ZERO_REG != 0, ADDR_W_MAX'(wr_addr));
  assign set_ok = bsy_set && !zero_hit(ZERO_REG != 0, ADDR_W_MAX'(bsy_addr));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // A mark and a retiring write on the same register in one cycle leave it busy.
  always_comb begin
    busy_next = busy;
    if (wr_ok)  busy_next[wr_addr]  = 1'b0;
    if (set_ok) busy_next[bsy_addr] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

  assign any_busy = |busy;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr_p;
    assign addr_p = rd_addr[p*ADDR_W +: ADDR_W];

    reg_file_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .clock    (clock),
      .reset    (reset),
      .en       (rd_en[p]),
      .addr     (addr_p),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .reg_data (regs[addr_p]),
      .busy_bit (busy[addr_p]),
      .data     (rd_data[p*DATA_W +: DATA_W]),
      .busy     (rd_busy[p])
    );
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a ZERO_REG=1 and a ZERO_REG=0 instance share stimulus;
// an array model predicts each cycle's outputs into per-instance queues.
module tb_reg_file_sb;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 16;
  localparam int PW     = DATA_W + 1;
  localparam int EW     = NUM_RD * PW + 1;

  logic clock = 1'b0;
  logic reset;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     bsy_set;
  logic [ADDR_W-1:0]        bsy_addr;
  logic [1:0][NUM_RD*DATA_W-1:0] rd_data;
  logic [1:0][NUM_RD-1:0]        rd_busy;
  logic [1:0]                    any_busy;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  reg_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)) u_dut_z (
    .clock(clock), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data[0]), .rd_busy(rd_busy[0]), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .bsy_set(bsy_set), .bsy_addr(bsy_addr), .any_busy(any_busy[0]));

  reg_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(0)) u_dut_n (
    .clock(clock), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data[1]), .rd_busy(rd_busy[1]), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .bsy_set(bsy_set), .bsy_addr(bsy_addr), .any_busy(any_busy[1]));

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] m_mem  [2][DEPTH];
  bit                m_busy [2][DEPTH];
  logic [DATA_W-1:0] m_d    [2][NUM_RD];
  bit                m_b    [2][NUM_RD];
  logic [EW-1:0]     exp_q0 [$];
  logic [EW-1:0]     exp_q1 [$];

  logic issued;
  logic applied;

  function automatic void model_clear();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        m_mem[i][k]  = '0;
        m_busy[i][k] = 1'b0;
      end
      for (int p = 0; p < NUM_RD; p++) begin
        m_d[i][p] = '0;
        m_b[i][p] = 1'b0;
      end
    end
  endfunction

  task automatic check(input string name, input int inst, input int port,
                       input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s inst%0d port%0d: got %h expected %h at %0t", name, inst, port, got, want, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic [NUM_RD-1:0] re, input logic [ADDR_W-1:0] a0,
                       input logic [ADDR_W-1:0] a1, input logic we,
                       input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                       input logic bs, input logic [ADDR_W-1:0] ba);
    logic [ADDR_W-1:0] ad [NUM_RD];
    logic [EW-1:0] e;
    bit zr;
    bit anyb;
    ad[0] = a0;
    ad[1] = a1;
    rd_en = re; rd_addr = {a1, a0};
    wr_en = we; wr_addr = wa; wr_data = wd;
    bsy_set = bs; bsy_addr = ba;
    issued = 1'b1;
    for (int i = 0; i < 2; i++) begin
      zr = (i == 0);
      // Reads observe the state before this edge's write and mark.
      for (int p = 0; p < NUM_RD; p++) begin
        if (re[p]) begin
          if (zr && ad[p] == 0) begin
            m_d[i][p] = '0; m_b[i][p] = 1'b0;
          end else if (we && wa == ad[p]) begin
            m_d[i][p] = wd; m_b[i][p] = 1'b0;
          end else begin
            m_d[i][p] = m_mem[i][ad[p]]; m_b[i][p] = m_busy[i][ad[p]];
          end
        end
      end
      if (we && !(zr && wa == 0)) begin
        m_mem[i][wa]  = wd;
        m_busy[i][wa] = 1'b0;
      end
      if (bs && !(zr && ba == 0)) m_busy[i][ba] = 1'b1;
      anyb = 1'b0;
      for (int k = 0; k < DEPTH; k++) anyb = anyb | m_busy[i][k];
      for (int p = 0; p < NUM_RD; p++) e[p*PW +: PW] = {m_b[i][p], m_d[i][p]};
      e[EW-1] = anyb;
      if (i == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
    end
    @(posedge clock);
    #1;
    issued = 1'b0;
    rd_en = '0; wr_en = 1'b0; bsy_set = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    #1;
    reset = 1'b1;
    model_clear();
    #2;
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < NUM_RD; p++) begin
        check("rst_data", i, p, rd_data[i][p*DATA_W +: DATA_W], '0);
        check("rst_busy", i, p, DATA_W'(rd_busy[i][p]), '0);
      end
      check("rst_any", i, 0, DATA_W'(any_busy[i]), '0);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clock or posedge reset) begin
    if (reset) applied <= 1'b0;
    else       applied <= issued;
  end

  always @(negedge clock) begin
    logic [EW-1:0] e;
    if (applied) begin
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
          n_fail++;
          $display("FAIL sb_empty inst%0d: got no expectation, required one at %0t", i, $time);
        end else begin
          e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          for (int p = 0; p < NUM_RD; p++) begin
            check("rd_data", i, p, rd_data[i][p*DATA_W +: DATA_W], e[p*PW +: DATA_W]);
            check("rd_busy", i, p, DATA_W'(rd_busy[i][p]), DATA_W'(e[p*PW + DATA_W]));
          end
          check("any_busy", i, 0, DATA_W'(any_busy[i]), DATA_W'(e[EW-1]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; issued = 1'b0;
    rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    bsy_set = 1'b0; bsy_addr = '0;
    model_clear();
    #2;
    for (int i = 0; i < 2; i++) begin
      check("init_data", i, 0, rd_data[i][DATA_W-1:0], '0);
      check("init_any", i, 0, DATA_W'(any_busy[i]), '0);
    end
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // reset mid-stream
    cycle(2'b00, 4'd0, 4'd0, 1'b1, 4'd3, 16'hBEEF, 1'b1, 4'd4);
    cycle(2'b01, 4'd3, 4'd0, 1'b0, 4'd0, 16'h0,    1'b0, 4'd0);
    do_reset();
    cycle(2'b11, 4'd3, 4'd4, 1'b0, 4'd0, 16'h0,    1'b0, 4'd0);
    // bypass
    cycle(2'b11, 4'd5, 4'd6, 1'b1, 4'd5, 16'h1234, 1'b0, 4'd0);
    // scoreboard set, then retiring write with same-cycle read
    cycle(2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0,    1'b1, 4'd7);
    cycle(2'b11, 4'd7, 4'd7, 1'b0, 4'd0, 16'h0,    1'b0, 4'd0);
    cycle(2'b01, 4'd7, 4'd0, 1'b1, 4'd7, 16'h00AA, 1'b0, 4'd0);
    // set/write collision
    cycle(2'b00, 4'd0, 4'd0, 1'b1, 4'd2, 16'h0F0F, 1'b1, 4'd2);
    cycle(2'b11, 4'd2, 4'd2, 1'b0, 4'd0, 16'h0,    1'b0, 4'd0);
    // register 0 behaviour on both instances
    cycle(2'b00, 4'd0, 4'd0, 1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0);
    cycle(2'b11, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0,    1'b0, 4'd0);
    cycle(2'b01, 4'd0, 4'd0, 1'b1, 4'd0, 16'h5555, 1'b0, 4'd0);
    // hold
    cycle(2'b00, 4'd0, 4'd0, 1'b1, 4'd1, 16'h0042, 1'b0, 4'd0);
    cycle(2'b01, 4'd1, 4'd0, 1'b0, 4'd0, 16'h0,    1'b0, 4'd0);
    cycle(2'b00, 4'd1, 4'd0, 1'b1, 4'd1, 16'h0099, 1'b0, 4'd0);
    cycle(2'b00, 4'd1, 4'd0, 1'b0, 4'd0, 16'h0,    1'b0, 4'd0);
    cycle(2'b01, 4'd1, 4'd0, 1'b0, 4'd0, 16'h0,    1'b0, 4'd0);

    // randomized traffic with one mid-stream reset
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      cycle(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
            1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)));
    end

    repeat (3) @(posedge clock);
    #1;
    check("drain", 0, 0, DATA_W'(exp_q0.size() + exp_q1.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
